// File: rtl/prog_host_ctrl.sv
// Host-side master for the pipeline programming/debug ports.
// One command in, timed port transactions out, one response back.
module prog_host_ctrl #(
  parameter int IMEM_AW = 9,
  parameter int DMEM_AW = 8,
  parameter int DMEM_DW = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [IMEM_AW-1:0] cmd_addr,
  input  logic [DMEM_DW-1:0] cmd_wdata,
  input  logic               abort,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DMEM_DW-1:0] rsp_data,
  output logic               rsp_err,
  output logic               rsp_aborted,
  output logic               busy,
  output logic               run,
  output logic               step,
  output logic               pc_reset_pulse,
  output logic               imem_prog_we,
  output logic [IMEM_AW-1:0] imem_prog_addr,
  output logic [31:0]        imem_prog_wdata,
  output logic               dmem_prog_en,
  output logic               dmem_prog_we,
  output logic [DMEM_AW-1:0] dmem_prog_addr,
  output logic [DMEM_DW-1:0] dmem_prog_wdata,
  input  logic [DMEM_DW-1:0] dmem_prog_rdata
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_IWR  = 3'd1;
  localparam logic [2:0] OP_DWR  = 3'd2;
  localparam logic [2:0] OP_DRD  = 3'd3;
  localparam logic [2:0] OP_PCR  = 3'd4;
  localparam logic [2:0] OP_RUN  = 3'd5;
  localparam logic [2:0] OP_STEP = 3'd6;

  typedef enum logic [2:0] {
    IDLE, PULSE, GAP, RD_EN, RD_WAIT, RUNNING, RSP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;
  logic                 rvld_q, rvld_d;
  logic [DMEM_DW-1:0]   rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 abt_q, abt_d;
  logic                 run_q, run_d;
  logic                 step_q, step_d;
  logic                 pcr_q, pcr_d;
  logic                 iwe_q, iwe_d;
  logic [IMEM_AW-1:0]   iaddr_q, iaddr_d;
  logic [31:0]          iwdata_q, iwdata_d;
  logic                 den_q, den_d;
  logic                 dwe_q, dwe_d;
  logic [DMEM_AW-1:0]   daddr_q, daddr_d;
  logic [DMEM_DW-1:0]   dwdata_q, dwdata_d;
  logic [CNT_W-1:0]     n_cyc;
  logic                 accept;

  assign n_cyc  = cmd_wdata[CNT_W-1:0];
  assign accept = cmd_valid & rdy_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    abt_d    = abt_q;
    run_d    = 1'b0;
    step_d   = 1'b0;
    pcr_d    = 1'b0;
    iwe_d    = 1'b0;
    den_d    = 1'b0;
    dwe_d    = 1'b0;
    iaddr_d  = iaddr_q;
    iwdata_d = iwdata_q;
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          iaddr_d  = cmd_addr;
          iwdata_d = cmd_wdata[31:0];
          daddr_d  = cmd_addr[DMEM_AW-1:0];
          dwdata_d = cmd_wdata;
          rdata_d  = '0;
          err_d    = 1'b0;
          abt_d    = 1'b0;
          state_d  = PULSE;
          case (cmd_op)
            OP_IWR:  iwe_d = 1'b1;
            OP_DWR: begin
              den_d = 1'b1;
              dwe_d = 1'b1;
            end
            OP_DRD: begin
              den_d    = 1'b1;
              dwdata_d = '0;
              state_d  = RD_EN;
            end
            OP_PCR:  pcr_d  = 1'b1;
            OP_STEP: step_d = 1'b1;
            OP_RUN: begin
              if (n_cyc == '0) begin
                state_d = RSP;
              end else begin
                run_d   = 1'b1;
                cnt_d   = n_cyc;
                state_d = RUNNING;
              end
            end
            OP_NOP:  state_d = RSP;
            default: begin
              err_d   = 1'b1;
              state_d = RSP;
            end
          endcase
        end
      end
      PULSE:   state_d = GAP;
      GAP:     state_d = RSP;
      RD_EN:   state_d = RD_WAIT;
      RD_WAIT: begin
        rdata_d = dmem_prog_rdata;
        state_d = RSP;
      end
      RUNNING: begin
        // cnt_q counts run cycles still owed, including the current one
        if (abort) begin
          abt_d   = 1'b1;
          cnt_d   = '0;
          state_d = RSP;
        end else if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = RSP;
        end else begin
          run_d = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RSP: begin
        if (rspready_ok(rsp_ready)) begin
          rdata_d = '0;
          err_d   = 1'b0;
          abt_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
    rvld_d = (state_d == RSP);
  end

  function automatic logic rspready_ok(input logic r);
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      rvld_q   <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      abt_q    <= 1'b0;
      run_q    <= 1'b0;
      step_q   <= 1'b0;
      pcr_q    <= 1'b0;
      iwe_q    <= 1'b0;
      iaddr_q  <= '0;
      iwdata_q <= '0;
      den_q    <= 1'b0;
      dwe_q    <= 1'b0;
      daddr_q  <= '0;
      dwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      rvld_q   <= rvld_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      abt_q    <= abt_d;
      run_q    <= run_d;
      step_q   <= step_d;
      pcr_q    <= pcr_d;
      iwe_q    <= iwe_d;
      iaddr_q  <= iaddr_d;
      iwdata_q <= iwdata_d;
      den_q    <= den_d;
      dwe_q    <= dwe_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
    end
  end

  assign cmd_ready       = rdy_q;
  assign busy            = busy_q;
  assign rsp_valid       = rvld_q;
  assign rsp_data        = rdata_q;
  assign rsp_err         = err_q;
  assign rsp_aborted     = abt_q;
  assign run             = run_q;
  assign step            = step_q;
  assign pc_reset_pulse  = pcr_q;
  assign imem_prog_we    = iwe_q;
  assign imem_prog_addr  = iaddr_q;
  assign imem_prog_wdata = iwdata_q;
  assign dmem_prog_en    = den_q;
  assign dmem_prog_we    = dwe_q;
  assign dmem_prog_addr  = daddr_q;
  assign dmem_prog_wdata = dwdata_q;

endmodule

// File: doc/prog_host_ctrl.md
Name: prog_host_ctrl

Overview:
- Host-side master for the pipeline's programming and debug ports: the initiator end of the imem/dmem programming interface and the run/step/PC-reset controls.
- Accepts one command at a time on a valid/ready command channel.
- Converts each command into correctly timed port transactions: one-cycle write pulses, synchronous-read capture, and N-cycle run windows.
- Returns exactly one response per command on a valid/ready response channel. Sits between a host link (UART/register bridge) and the pipeline top.

Parameters:
IMEM_AW, 9, imem programming address width
DMEM_AW, 8, dmem programming address width
DMEM_DW, 64, dmem data width
CNT_W, 16, width of the run-cycle counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready; high only in IDLE
cmd_op  in  3  0 NOP, 1 IMEM_WR, 2 DMEM_WR, 3 DMEM_RD, 4 PC_RST, 5 RUN, 6 STEP, 7 illegal
cmd_addr  in  9  target address; dmem uses bits [7:0]
cmd_wdata  in  64  write data; imem uses [31:0]; RUN uses [CNT_W-1:0] as cycle count N
abort  in  1  terminates an active RUN
rsp_valid  out  1  response available; held until rsp_ready
rsp_ready  in  1  host accepts response
rsp_data  out  64  DMEM_RD data, otherwise 0
rsp_err  out  1  1 for illegal op
rsp_aborted  out  1  1 if RUN was cut short by abort
busy  out  1  high in every state except IDLE
run  out  1  to pipeline
step  out  1  to pipeline
pc_reset_pulse  out  1  to pipeline
imem_prog_we  out  1  to pipeline
imem_prog_addr  out  9  to pipeline
imem_prog_wdata  out  32  to pipeline
dmem_prog_en  out  1  to pipeline
dmem_prog_we  out  1  to pipeline
dmem_prog_addr  out  8  to pipeline
dmem_prog_wdata  out  64  to pipeline
dmem_prog_rdata  in  64  from pipeline; synchronous read

Behaviour:
- Reset, asynchronous: every output = 0, state = IDLE, counter = 0. Reset mid-operation drops all strobes immediately and loses the response.
- All pipeline-facing outputs are registered.
- Address and data outputs are loaded at accept and hold their value until the next accept.
- States: IDLE, PULSE, GAP, RD_EN, RD_WAIT, RUNNING, RSP.
- Accept edge E0: cmd_valid & cmd_ready. Operands are latched and the op is decoded.
- IMEM_WR / DMEM_WR / PC_RST / STEP:
  - E0 → PULSE. Exactly one of the following is high for one cycle: imem_prog_we; dmem_prog_en+dmem_prog_we; pc_reset_pulse; step.
  - E1 → GAP, all strobes 0.
  - E2 → RSP.
- DMEM_RD:
  - E0 → RD_EN: dmem_prog_en=1, dmem_prog_we=0, dmem_prog_wdata=0.
  - E1 → RD_WAIT, en=0.
  - E2: dmem_prog_rdata is captured into rsp_data → RSP.
- RUN:
  - N=0: E0 → RSP directly; run is never asserted.
  - N>0: E0 → RUNNING with run=1. run stays high for exactly N clock cycles, then the block goes to RSP with run=0.
  - abort sampled high in RUNNING: run drops at the next edge, rsp_aborted=1, → RSP.
  - abort is ignored in all other states.
  - N is taken modulo 2^CNT_W; the maximum is 65535.
- NOP: E0 → RSP with rsp_data=0.
- Illegal op: E0 → RSP with rsp_err=1. No strobes are asserted.
- RSP:
  - rsp_valid=1 and the response fields are stable until rsp_ready.
  - At the handshake edge → IDLE: rsp_valid=0, rsp_err=0, rsp_aborted=0.
  - cmd_ready returns high in the cycle after the handshake; no command is accepted in the same cycle as a response handshake.
- run, step, pc_reset_pulse, imem_prog_we and dmem_prog_en are mutually exclusive at all times.
- cmd_valid while busy is ignored; it is not accepted or queued.

Test Plan:
- DMEM_WR addr 0x00 data 0xDEADBEEFCAFE1234, then DMEM_RD addr 0x00 against a synchronous BRAM model → dmem_prog_we high exactly 1 cycle; rsp_data=0xDEADBEEFCAFE1234 at RSP, 2 cycles after read accept.
- IMEM_WR addr 0 data 0x40200000, then addr 1..4 data 0 → 5 single-cycle imem_prog_we pulses with matching addr/wdata; 5 responses with rsp_err=0.
- PC_RST then RUN N=12 → pc_reset_pulse high 1 cycle; run high exactly 12 consecutive cycles; one response with rsp_aborted=0. RUN N=0 → no run, immediate response.
- RUN N=100 with abort pulsed on run cycle 5 → run high 5 cycles; rsp_aborted=1.
- cmd_op=7 → no strobes; rsp_err=1. Hold rsp_ready=0 for 10 cycles → rsp_valid and fields stable, cmd_ready=0 throughout.
- Assert reset during RUN N=50 at cycle 20 → run and all outputs 0 immediately; no response; next command accepted normally after reset release.
